// File: rtl/cdf_pipeline_if.sv
// cdf_pipeline_if: start/done handshake plus m2 histogram and m3 CDF scratchpad ports.
interface cdf_pipeline_if;
  logic         start;
  logic         done;
  logic [127:0] m2ReadVal;
  logic [15:0]  m2ReadAddr;
  logic [15:0]  m2WriteAddr;
  logic [127:0] m2WriteVal;
  logic         m2WE;
  logic [15:0]  m3WriteAddr;
  logic [127:0] m3WriteVal;
  logic         m3WE;
  logic [31:0]  cdfMin;
  logic [31:0]  cdfTotal;
  modport master (
    output start, m2ReadVal,
    input  done, m2ReadAddr, m2WriteAddr, m2WriteVal, m2WE,
           m3WriteAddr, m3WriteVal, m3WE, cdfMin, cdfTotal
  );
  modport slave (
    input  start, m2ReadVal,
    output done, m2ReadAddr, m2WriteAddr, m2WriteVal, m2WE,
           m3WriteAddr, m3WriteVal, m3WE, cdfMin, cdfTotal
  );
endinterface

// File: rtl/cdf_pipeline.sv
// cdf_pipeline: walks 256 histogram bins and writes the running CDF to m3.
// Define CDF_CLEAR_EN to zero each m2 bin in the cycle its CDF is written.
module cdf_pipeline (
  input logic          clock,
  input logic          rst_n,
  cdf_pipeline_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;
  state_t      state, state_nx;
  logic        issue, go, dr;
  logic        rd_v, w_v;
  logic [7:0]  addr, rd_addr, w_addr;
  logic [15:0] cnt;
  logic [31:0] acc, sum, cdf_min, cdf_total;
  logic        unused_hi;
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = bus.start ? READ : IDLE;
      READ:  state_nx = addr == 8'd255 ? DRAIN : READ;
      DRAIN: state_nx = dr ? FIN : DRAIN;
      FIN:   state_nx = IDLE;
    endcase
  end
  always_comb begin
    issue = state == READ;
    go    = state == IDLE && bus.start;
  end
  // Read data for rd_addr arrives one cycle after the address is issued.
  assign cnt = bus.m2ReadVal[31:16] == 16'hAAAA ? bus.m2ReadVal[15:0] : 16'h0;
  assign sum = acc + {16'h0, cnt};
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      dr        <= 1'b0;
      addr      <= 8'h0;
      rd_v      <= 1'b0;
      rd_addr   <= 8'h0;
      w_v       <= 1'b0;
      w_addr    <= 8'h0;
      acc       <= 32'h0;
      cdf_min   <= 32'h0;
      cdf_total <= 32'h0;
    end else begin
      dr        <= state == DRAIN ? ~dr : 1'b0;
      addr      <= issue && state_nx == READ ? addr + 8'd1 : state_nx == IDLE ? 8'h0 : addr;
      rd_v      <= issue;
      rd_addr   <= addr;
      w_v       <= rd_v;
      w_addr    <= rd_addr;
      acc       <= go ? 32'h0 : rd_v ? sum : acc;
      cdf_min   <= go ? 32'h0 : rd_v && cdf_min == 32'h0 ? sum : cdf_min;
      cdf_total <= go ? 32'h0 : rd_v && rd_addr == 8'd255 ? sum : cdf_total;
    end
  assign unused_hi       = ^bus.m2ReadVal[127:32];
  assign bus.done        = state == FIN;
  assign bus.m2ReadAddr  = {8'h0, addr};
  assign bus.m3WE        = w_v;
  assign bus.m3WriteAddr = {8'h0, w_addr};
  assign bus.m3WriteVal  = w_v ? {80'h0, 16'hAAAA, acc} : 128'h0;
  assign bus.cdfMin      = cdf_min;
  assign bus.cdfTotal    = cdf_total;
`ifdef CDF_CLEAR_EN
  assign bus.m2WE        = w_v;
  assign bus.m2WriteAddr = {8'h0, w_addr};
  assign bus.m2WriteVal  = 128'h0;
`else
  assign bus.m2WE        = 1'b0;
  assign bus.m2WriteAddr = 16'h0;
  assign bus.m2WriteVal  = 128'h0;
`endif
endmodule

// File: doc/cdf_pipeline.md
# cdf_pipeline

Second stage of the histogram equalizer. It runs after the counting stage has filled the scratchpad histogram (m2), one 16-bit count per pixel value at addresses 0..255. The block walks all 256 bins in order and writes the running cumulative distribution (CDF) to scratchpad 2 (m3). It also reports the CDF minimum and the total pixel count, which the mapping stage uses to build the equalization table.

## Interface
Parameters:
- none. Bin count (256), tag value (16'hAAAA) and widths are fixed.

Ports:
- clock  input  1  system clock; all state changes on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a pass; sampled only in IDLE.
- m2ReadVal  input  128  histogram word from m2.
  - [31:16] is the valid tag; [15:0] is the count.
- m2ReadAddr  output  16  histogram bin address.
- m2WriteAddr  output  16  histogram clear address; used only with CDF_CLEAR_EN.
- m2WriteVal  output  128  histogram clear data; used only with CDF_CLEAR_EN.
- m2WE  output  1  histogram clear write enable.
- m3WriteAddr  output  16  CDF bin address.
- m3WriteVal  output  128  CDF word: {80'b0, 16'hAAAA, cdf[31:0]}.
- m3WE  output  1  CDF write enable.
- cdfMin  output  32  first non-zero CDF value.
- cdfTotal  output  32  final CDF value, i.e. total pixel count.
- done  output  1  one-cycle pulse at the end of a pass.

## Operation
- States:
  - IDLE: waits for start.
  - READ: issues addresses 0..255, one per cycle.
  - DRAIN: two cycles that retire the last reads.
  - FIN: pulses done, then returns to IDLE.
- Transitions:
  - IDLE -> READ on start=1.
  - READ -> DRAIN after address 255 is issued.
  - DRAIN -> FIN after 2 cycles.
  - FIN -> IDLE unconditionally.
- m2 read is synchronous: data for the address issued after edge k is valid after edge k+1.
- Bin count = m2ReadVal[15:0] if m2ReadVal[31:16]==16'hAAAA, else 0. An untouched bin counts as empty.
- Accumulator acc (32 bits) is cleared on start.
- For each bin: acc <= acc + count; write {80'b0, 16'hAAAA, acc+count} to m3 at the bin address.
- No overflow is possible: 256×65535 < 2^32. No saturation logic.
- cdfMin:
  - Loaded with the first non-zero acc+count of the pass.
  - Stays 0 if every bin is empty.
  - Cleared on start.
- cdfTotal = acc after bin 255.
- cdfMin and cdfTotal hold their values until the next start.
- start is ignored outside IDLE.
- m2ReadAddr holds 255 through DRAIN/FIN and returns to 0 in IDLE.

## Timing
- Reset value of every output is 0. State goes to IDLE and acc is cleared.
- Reset mid-pass aborts immediately:
  - no further m3/m2 writes occur;
  - done does not pulse;
  - the partial m3 contents are left as written.
- Edge 0 is the edge that samples start=1.
- After edge k (k=0..255): m2ReadAddr=k.
- After edge k+2: m3WE=1, m3WriteAddr=k, m3WriteVal=CDF(k).
  - First write appears after edge 2; last after edge 257.
- m3WE=0 after edge 258.
- cdfTotal and cdfMin are final after edge 257.
- done=1 for exactly the cycle after edge 258. The block accepts a new start at edge 259.
- Pass length is 259 cycles start-to-idle. Throughput is 1 bin per cycle with no stalls.

## Configuration
- CDF_CLEAR_EN defined:
  - Each histogram bin is zeroed after it is consumed, so m2 is ready for the next frame.
  - In the same cycle as the m3 write for bin k: m2WE=1, m2WriteAddr=k, m2WriteVal=128'h0.
  - m2 has independent read and write ports, so the clear never collides with a read.
- CDF_CLEAR_EN undefined: m2WE, m2WriteAddr and m2WriteVal are held at 0 permanently.

## Test plan
- Uniform image: all 256 bins = {16'hAAAA, 16'd1}, start pulse.
  - m3 bin k = k+1.
  - cdfMin=1, cdfTotal=256.
  - done after edge 258.
- Sparse image:
  - Setup: only bin 10=5 and bin 200=7 tagged; all others untagged garbage (m2ReadVal[31:16]=16'h1234).
  - Expected m3: bins 0..9 = 0, bins 10..199 = 5, bins 200..255 = 12.
  - Expected outputs: cdfMin=5, cdfTotal=12.
- Empty histogram: no tags anywhere.
  - All m3 CDF = 0, cdfMin=0, cdfTotal=0.
  - done still pulses.
- Max counts: all bins = 16'hFFFF.
  - cdfTotal = 32'h00FFFF00 (256×65535).
  - m3 bin 255 low word matches it.
- Reset at edge 100, then start again:
  - outputs return to 0 and no done pulse is seen for the aborted pass;
  - the second pass completes with correct values.
  - Also check that a second start pulsed mid-pass is ignored.
- With CDF_CLEAR_EN:
  - m2 write k is coincident with m3 write k.
  - All 256 m2 words read 0 after done.
  - Without the macro, m2WE is never asserted.
